// File: rtl/bsg_countdown_sched.sv
//==============================================================================
//  Module      : bsg_countdown_sched
//  Description : One shared down counter, time-multiplexed among els_p
//                requesters. A round-robin arbiter grants an idle counter,
//                the grantee's value is counted down on tick_i, and the owner
//                gets a one-cycle done pulse when the count reaches zero.
//                abort_i cancels the active countdown without a done pulse.
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bsg_countdown_sched #(
    parameter  int els_p     = 4,
    parameter  int width_p   = 16,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   val_i,
    output logic [els_p-1:0]           yumi_o,
    input  logic                       tick_i,
    input  logic                       abort_i,
    output logic [els_p-1:0]           done_o,
    output logic                       busy_o,
    output logic [lg_els_lp-1:0]       owner_o,
    output logic [width_p-1:0]         count_r_o
);

    localparam logic [lg_els_lp-1:0] c_last_id = lg_els_lp'(els_p - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [width_p-1:0]   r_count;
    logic [width_p-1:0]   w_count_nxt;
    logic [lg_els_lp-1:0] r_owner;
    logic [lg_els_lp-1:0] w_owner_nxt;
    logic [lg_els_lp-1:0] r_rr_ptr;
    logic [lg_els_lp-1:0] w_rr_nxt;

    logic                 w_any;
    logic [lg_els_lp-1:0] w_winner;
    logic [width_p-1:0]   w_load;
    logic [els_p-1:0]     w_yumi;
    logic [els_p-1:0]     w_done;
    int                   w_ptr;
    int                   w_dist;
    int                   w_best;

    // Round-robin pick: the valid requester closest (cyclically) at or after rr_ptr
    always_comb begin
        w_any    = |v_i;
        w_winner = '0;
        w_load   = '0;
        w_ptr    = int'(r_rr_ptr);
        w_dist   = 0;
        w_best   = els_p;
        for (int j = 0; j < els_p; j++) begin
            if (v_i[j]) begin
                w_dist = (j >= w_ptr) ? (j - w_ptr) : (j + els_p - w_ptr);
                if (w_dist < w_best) begin
                    w_best   = w_dist;
                    w_winner = lg_els_lp'(j);
                    w_load   = val_i[j*width_p +: width_p];
                end
            end
        end
    end

    // Next-state and pulse outputs; abort outranks expiry, grants only from IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_yumi      = '0;
        w_done      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_yumi      = els_p'(1) << w_winner;
                    w_count_nxt = w_load;
                    w_owner_nxt = w_winner;
                    w_rr_nxt    = (w_winner == c_last_id) ? '0 : w_winner + lg_els_lp'(1);
                    w_state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (abort_i) begin
                    w_count_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_count == '0) begin
                    w_done      = els_p'(1) << r_owner;
                    w_state_nxt = ST_IDLE;
                end else if (tick_i) begin
                    w_count_nxt = r_count - width_p'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset is asynchronous so a countdown dies without a done pulse
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // Pulses are gated by reset so requests held during reset are never acknowledged
    always_comb begin
        yumi_o    = reset_n_i ? w_yumi : '0;
        done_o    = reset_n_i ? w_done : '0;
        busy_o    = (r_state == ST_COUNT);
        owner_o   = r_owner;
        count_r_o = r_count;
    end

endmodule

`default_nettype wire
